// File: rtl/dac_adc_pkg.sv
// Shared definitions for the DAC/ADC sample-transport blocks: FSM state codes,
// sample/byte widths and the byte-pair to sample packing helper.
package dac_adc_pkg;

    localparam int SAMPLE_W    = 12;
    localparam int BYTE_W      = 8;
    localparam int HI_NIBBLE_W = 4;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_LO = 2'd1;
    localparam logic [1:0] WAIT_HI = 2'd2;

    typedef logic [SAMPLE_W-1:0]    sample_t;
    typedef logic [BYTE_W-1:0]      byte_t;
    typedef logic [HI_NIBBLE_W-1:0] nibble_t;

    // Sample layout on the wire: low byte first, then the top nibble.
    function automatic sample_t pack_sample(input nibble_t hi, input byte_t lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/ctrl_uart2fifo_if.sv
// Handshake bundle between the UART receiver, the DAC playback FIFO and the
// UART-to-FIFO controller. master = controller view, slave = surrounding logic.
interface ctrl_uart2fifo_if #(
    parameter int CNT_W = 16
);
    import dac_adc_pkg::*;

    logic             start_all;
    logic             uart_rx_done;
    byte_t            uart_rx_data;
    logic             fifo_wrreq;
    sample_t          fifo_wrdata;
    logic             fifo_full;
    logic             fifo_almost_full;
    logic             dac_play_start;
    logic             err_overflow;
    logic             err_timeout;
    logic [CNT_W-1:0] words_written;

    modport master (
        input  start_all,
        input  uart_rx_done,
        input  uart_rx_data,
        input  fifo_full,
        input  fifo_almost_full,
        output fifo_wrreq,
        output fifo_wrdata,
        output dac_play_start,
        output err_overflow,
        output err_timeout,
        output words_written
    );

    modport slave (
        output start_all,
        output uart_rx_done,
        output uart_rx_data,
        output fifo_full,
        output fifo_almost_full,
        input  fifo_wrreq,
        input  fifo_wrdata,
        input  dac_play_start,
        input  err_overflow,
        input  err_timeout,
        input  words_written
    );

endinterface

// File: rtl/byte_timeout_timer.sv
// Inter-byte watchdog: counts while run=1, expired flags the cycle in which the
// count sits at TIMEOUT_CYCLES-1. clr has priority over run.
module byte_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            count_reg <= '0;
        end else if (run) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = run && (count_reg == LAST);

endmodule

// File: rtl/ctrl_uart2fifo.sv
// Reassembles 12-bit samples from UART byte pairs and writes them to the DAC FIFO.
// Optional macro CTRL_UART2FIFO_NIBBLE_CHECK_EN: non-zero high nibble forces a resync.
module ctrl_uart2fifo
    import dac_adc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    ctrl_uart2fifo_if.master   bus
);

    logic [1:0]       state_reg, state_next;
    byte_t            lo_reg, lo_next;
    logic             fifo_wrreq_reg, fifo_wrreq_next;
    sample_t          fifo_wrdata_reg, fifo_wrdata_next;
    logic [CNT_W-1:0] words_written_reg, words_written_next;
    logic             play_armed_reg, play_armed_next;
    logic             dac_play_start_reg, dac_play_start_next;
    logic             err_overflow_reg, err_overflow_next;
    logic             err_timeout_reg, err_timeout_next;

    logic tmr_clr;
    logic tmr_run;
    logic tmr_expired;
    logic nibble_bad;

    byte_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .srst    (rst),
        .clr     (tmr_clr),
        .run     (tmr_run),
        .expired (tmr_expired)
    );

`ifdef CTRL_UART2FIFO_NIBBLE_CHECK_EN
    assign nibble_bad = (bus.uart_rx_data[BYTE_W-1:HI_NIBBLE_W] != '0);
`else
    logic unused_hi_nibble;
    assign unused_hi_nibble = ^bus.uart_rx_data[BYTE_W-1:HI_NIBBLE_W];
    assign nibble_bad       = 1'b0;
`endif

    always_comb begin
        state_next          = state_reg;
        lo_next             = lo_reg;
        fifo_wrreq_next     = 1'b0;
        fifo_wrdata_next    = fifo_wrdata_reg;
        words_written_next  = words_written_reg;
        play_armed_next     = play_armed_reg;
        dac_play_start_next = 1'b0;
        err_overflow_next   = 1'b0;
        err_timeout_next    = 1'b0;
        tmr_clr             = 1'b0;
        tmr_run             = 1'b0;

        if (play_armed_reg && (state_reg != IDLE) && bus.fifo_almost_full) begin
            dac_play_start_next = 1'b1;
            play_armed_next     = 1'b0;
        end

        // Restart beats everything, including a byte arriving in the same cycle.
        if (bus.start_all) begin
            state_next         = WAIT_LO;
            words_written_next = '0;
            play_armed_next    = 1'b1;
            tmr_clr            = 1'b1;
        end else begin
            case (state_reg)
                IDLE: ;
                WAIT_LO: begin
                    if (bus.uart_rx_done) begin
                        lo_next    = bus.uart_rx_data;
                        tmr_clr    = 1'b1;
                        state_next = WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    tmr_run = 1'b1;
                    if (bus.uart_rx_done) begin
                        if (nibble_bad) begin
                            // Treat the stray byte as the start of a fresh pair.
                            err_timeout_next = 1'b1;
                            lo_next          = bus.uart_rx_data;
                            tmr_clr          = 1'b1;
                        end else begin
                            if (!bus.fifo_full) begin
                                fifo_wrreq_next    = 1'b1;
                                fifo_wrdata_next   = pack_sample(bus.uart_rx_data[HI_NIBBLE_W-1:0], lo_reg);
                                words_written_next = words_written_reg + 1'b1;
                            end else begin
                                err_overflow_next = 1'b1;
                            end
                            state_next = WAIT_LO;
                        end
                    end else if (tmr_expired) begin
                        err_timeout_next = 1'b1;
                        state_next       = WAIT_LO;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IDLE;
            lo_reg             <= '0;
            fifo_wrreq_reg     <= 1'b0;
            fifo_wrdata_reg    <= '0;
            words_written_reg  <= '0;
            play_armed_reg     <= 1'b0;
            dac_play_start_reg <= 1'b0;
            err_overflow_reg   <= 1'b0;
            err_timeout_reg    <= 1'b0;
        end else begin
            state_reg          <= state_next;
            lo_reg             <= lo_next;
            fifo_wrreq_reg     <= fifo_wrreq_next;
            fifo_wrdata_reg    <= fifo_wrdata_next;
            words_written_reg  <= words_written_next;
            play_armed_reg     <= play_armed_next;
            dac_play_start_reg <= dac_play_start_next;
            err_overflow_reg   <= err_overflow_next;
            err_timeout_reg    <= err_timeout_next;
        end
    end

    assign bus.fifo_wrreq     = fifo_wrreq_reg;
    assign bus.fifo_wrdata    = fifo_wrdata_reg;
    assign bus.words_written  = words_written_reg;
    assign bus.dac_play_start = dac_play_start_reg;
    assign bus.err_overflow   = err_overflow_reg;
    assign bus.err_timeout    = err_timeout_reg;

endmodule

// File: tb/tb_ctrl_uart2fifo.sv
// Directed bench for ctrl_uart2fifo: byte pairs, overflow, timeout, play start,
// restart and reset behaviour, with hand-computed expectations.
module tb_ctrl_uart2fifo;

    localparam int TO    = 16;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ctrl_uart2fifo_if #(.CNT_W(CNT_W)) bus ();

    ctrl_uart2fifo #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int play_cnt = 0;

    logic        got_wr;
    logic        got_ovf;
    logic        got_to;
    logic [11:0] got_data;

    always @(negedge clk) begin
        if (bus.dac_play_start) play_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, act);
        end
    endtask

    // Called at a negedge; presents one byte for one clock, then samples outputs.
    task automatic send(input logic [7:0] b, input logic with_start);
        bus.uart_rx_done = 1'b1;
        bus.uart_rx_data = b;
        bus.start_all    = with_start;
        @(negedge clk);
        bus.uart_rx_done = 1'b0;
        bus.start_all    = 1'b0;
        got_wr   = bus.fifo_wrreq;
        got_data = bus.fifo_wrdata;
        got_ovf  = bus.err_overflow;
        got_to   = bus.err_timeout;
    endtask

    task automatic pulse_start();
        bus.start_all = 1'b1;
        @(negedge clk);
        bus.start_all = 1'b0;
    endtask

    task automatic pair(input logic [7:0] lo, input logic [7:0] hi,
                        input logic [11:0] exp_data, input int exp_ww, input string tag);
        send(lo, 1'b0);
        check({tag, "_lo_nowr"}, 32'(got_wr), 32'd0);
        send(hi, 1'b0);
        check({tag, "_wr"}, 32'(got_wr), 32'd1);
        check({tag, "_data"}, 32'(got_data), 32'(exp_data));
        check({tag, "_ww"}, 32'(bus.words_written), 32'(exp_ww));
    endtask

    initial begin
        int base;
        int n;

        bus.start_all        = 1'b0;
        bus.uart_rx_done     = 1'b0;
        bus.uart_rx_data     = 8'h00;
        bus.fifo_full        = 1'b0;
        bus.fifo_almost_full = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_wrreq", 32'(bus.fifo_wrreq), 32'd0);
        check("rst_wrdata", 32'(bus.fifo_wrdata), 32'd0);
        check("rst_ww", 32'(bus.words_written), 32'd0);
        check("rst_play", 32'(bus.dac_play_start), 32'd0);
        check("rst_ovf", 32'(bus.err_overflow), 32'd0);
        check("rst_to", 32'(bus.err_timeout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Bytes are ignored while idle
        send(8'h12, 1'b0);
        check("idle_b0", 32'(got_wr), 32'd0);
        send(8'h03, 1'b0);
        check("idle_b1", 32'(got_wr), 32'd0);

        // 1: basic pair
        pulse_start();
        pair(8'h34, 8'h02, 12'h234, 1, "t1");
        @(negedge clk);
        check("t1_oneshot", 32'(bus.fifo_wrreq), 32'd0);
        check("t1_hold", 32'(bus.fifo_wrdata), 32'h234);

        // 2: overflow drops the sample
        send(8'h77, 1'b0);
        bus.fifo_full = 1'b1;
        send(8'h0F, 1'b0);
        bus.fifo_full = 1'b0;
        check("t2_nowr", 32'(got_wr), 32'd0);
        check("t2_ovf", 32'(got_ovf), 32'd1);
        check("t2_ww", 32'(bus.words_written), 32'd1);
        @(negedge clk);
        check("t2_ovf_oneshot", 32'(bus.err_overflow), 32'd0);
        pair(8'h45, 8'h06, 12'h645, 2, "t2b");

        // 3: timeout after TO cycles of silence
        send(8'hAA, 1'b0);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.err_timeout) begin
                n = k;
                break;
            end
        end
        check("t3_to_latency", 32'(n), 32'(TO));
        check("t3_nowr", 32'(bus.fifo_wrreq), 32'd0);
        check("t3_ww", 32'(bus.words_written), 32'd2);
        pair(8'h11, 8'h01, 12'h111, 3, "t3b");

        // High byte in the very expiry cycle wins over the timeout
        send(8'h22, 1'b0);
        repeat (TO - 1) @(negedge clk);
        send(8'h05, 1'b0);
        check("t3c_wr", 32'(got_wr), 32'd1);
        check("t3c_data", 32'(got_data), 32'h522);
        check("t3c_noto", 32'(got_to), 32'd0);
        @(negedge clk);
        check("t3c_noto_late", 32'(bus.err_timeout), 32'd0);
        check("t3c_ww", 32'(bus.words_written), 32'd4);

        // 4: play start once per start_all
        pulse_start();
        check("t4_ww_clr", 32'(bus.words_written), 32'd0);
        base = play_cnt;
        for (int i = 0; i < 8; i++) begin
            pair(8'(8'hA0 + i), 8'(i), 12'((i << 8) + 8'hA0 + i), i + 1, "t4");
        end
        check("t4_noplay", 32'(play_cnt - base), 32'd0);
        bus.fifo_almost_full = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_play1", 32'(play_cnt - base), 32'd1);
        bus.fifo_almost_full = 1'b0;
        repeat (2) @(negedge clk);
        bus.fifo_almost_full = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_noreplay", 32'(play_cnt - base), 32'd1);
        pulse_start();
        repeat (3) @(negedge clk);
        check("t4_rearm", 32'(play_cnt - base), 32'd2);
        bus.fifo_almost_full = 1'b0;

        // 5: restart mid-sample discards the partial
        pair(8'h01, 8'h01, 12'h101, 1, "t5a");
        send(8'h55, 1'b0);
        pulse_start();
        check("t5_ww_clr", 32'(bus.words_written), 32'd0);
        pair(8'h66, 8'h03, 12'h366, 1, "t5");

        // start_all beats a same-cycle byte, which is dropped
        send(8'h77, 1'b0);
        send(8'h08, 1'b1);
        check("t5c_nowr", 32'(got_wr), 32'd0);
        check("t5c_ww", 32'(bus.words_written), 32'd0);
        pair(8'h09, 8'h01, 12'h109, 1, "t5c");

        // Reset mid-sample: partial lost, back to idle
        send(8'h44, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_ww", 32'(bus.words_written), 32'd0);
        send(8'h12, 1'b0);
        check("rst2_b0", 32'(got_wr), 32'd0);
        send(8'h03, 1'b0);
        check("rst2_b1", 32'(got_wr), 32'd0);

        // 6: upper-nibble handling
        pulse_start();
        send(8'h10, 1'b0);
        send(8'hF2, 1'b0);
`ifdef CTRL_UART2FIFO_NIBBLE_CHECK_EN
        check("t6_nowr", 32'(got_wr), 32'd0);
        check("t6_to", 32'(got_to), 32'd1);
        send(8'h03, 1'b0);
        check("t6_wr", 32'(got_wr), 32'd1);
        check("t6_data", 32'(got_data), 32'h3F2);
        check("t6_ww", 32'(bus.words_written), 32'd1);
`else
        check("t6_wr", 32'(got_wr), 32'd1);
        check("t6_data", 32'(got_data), 32'h210);
        check("t6_noto", 32'(got_to), 32'd0);
        send(8'h03, 1'b0);
        check("t6_lo_nowr", 32'(got_wr), 32'd0);
        send(8'h00, 1'b0);
        check("t6b_data", 32'(got_data), 32'h003);
        check("t6b_ww", 32'(bus.words_written), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
